diff_mc_filter: RTL and testbench

- Multi-channel, time-multiplexed discrete differentiator.
- Per channel, computes either a first-order difference (x[n]-x[n-1]) or a second-order difference (x[n]-2x[n-1]+x[n-2]); the order is selected per sample.
- Sits after the ADC sample demux and before the peak/threshold detection stage.
- Uses valid/ready handshakes on both sides, so it can be back-pressured by downstream consumers.

---
 rtl/diff_pkg.sv | 29 ++
 rtl/diff_mc_filter_if.sv | 44 ++++
 rtl/diff_hist_bank.sv | 64 ++++++
 rtl/diff_mc_filter.sv | 157 +++++++++++++++
 tb/tb_diff_mc_filter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/diff_pkg.sv
// Shared encodings and arithmetic for the multi-channel differentiator.
// Holds one-hot FSM states, order codes, channel-index width and the difference function.
// Pure declarations; no timing or handshake behaviour of its own.
package diff_pkg;

  // One-hot controller states
  localparam logic [2:0] IDLE = 3'b001;
  localparam logic [2:0] CALC = 3'b010;
  localparam logic [2:0] HOLD = 3'b100;

  // Difference order selected per sample
  localparam logic ORD1 = 1'b0;
  localparam logic ORD2 = 1'b1;

  // Channel index width: at least one bit even for a single channel
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Difference on zero-extended operands; the low DW+2 bits are exact for DW-bit inputs
  function automatic logic signed [31:0] diff_calc(input logic signed [31:0] x,
                                                   input logic signed [31:0] h1,
                                                   input logic signed [31:0] h2,
                                                   input logic               ord);
    if (ord == ORD2) return x - (h1 <<< 1) + h2;
    else             return x - h1;
  endfunction

endpackage

// File: rtl/diff_mc_filter_if.sv
// Sample-in / result-out bundle of the differentiator, plus the history clear strobe.
// No latency; carries valid/ready on both sides.
// slave = filter view, master = producer/consumer view. out_sat exists only with DIFF_SAT_EN.
interface diff_mc_filter_if
  import diff_pkg::*;
#(
  parameter int DW  = 12,
  parameter int NCH = 4,
  parameter int OW  = DW + 2
);
  localparam int CW = chan_w(NCH);

  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic [CW-1:0]        in_chan;
  logic                 in_order;
  logic                 clr_hist;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_data;
  logic [CW-1:0]        out_chan;
  logic                 out_primed;
`ifdef DIFF_SAT_EN
  logic                 out_sat;
`endif

  modport slave (
    input  in_valid, in_data, in_chan, in_order, clr_hist, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_primed
`ifdef DIFF_SAT_EN
    , output out_sat
`endif
  );

  modport master (
    output in_valid, in_data, in_chan, in_order, clr_hist, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_primed
`ifdef DIFF_SAT_EN
    , input out_sat
`endif
  );

endinterface

// File: rtl/diff_hist_bank.sv
// Per-channel history store {h1, h2, cnt}: combinational read by channel, shift-in update.
// Read is zero-latency; update and clear take effect on the next edge.
// No backpressure; clear beats an update in the same cycle, out-of-range channels read as 0.
module diff_hist_bank #(
  parameter int DW  = 12,
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic [CW-1:0] rd_chan_i,
  output logic [DW-1:0] rd_h1_o,
  output logic [DW-1:0] rd_h2_o,
  output logic [1:0]    rd_cnt_o,
  input  logic          wr_en_i,
  input  logic [CW-1:0] wr_chan_i,
  input  logic [DW-1:0] wr_x_i
);

  logic [DW-1:0] h1_q  [NCH];
  logic [DW-1:0] h2_q  [NCH];
  logic [1:0]    cnt_q [NCH];

  // History shift and saturating prime count for the addressed channel; global clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        h1_q[i]  <= '0;
        h2_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else if (clr_i) begin
      for (int i = 0; i < NCH; i++) begin
        h1_q[i]  <= '0;
        h2_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (wr_en_i && (wr_chan_i == CW'(i))) begin
          h2_q[i] <= h1_q[i];
          h1_q[i] <= wr_x_i;
          if (cnt_q[i] != 2'd2) cnt_q[i] <= cnt_q[i] + 2'd1;
        end
      end
    end
  end

  // Read mux; a channel index with no entry yields an empty history
  always_comb begin
    rd_h1_o  = '0;
    rd_h2_o  = '0;
    rd_cnt_o = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_chan_i == CW'(i)) begin
        rd_h1_o  = h1_q[i];
        rd_h2_o  = h2_q[i];
        rd_cnt_o = cnt_q[i];
      end
    end
  end

endmodule

// File: rtl/diff_mc_filter.sv
// Time-multiplexed per-channel 1st/2nd-order differentiator (optional saturation: DIFF_SAT_EN).
// Latency: sample accepted at T -> out_valid at T+2; one sample per 3 cycles at best.
// Backpressure: result held in HOLD until out_ready; in_ready only in IDLE.
module diff_mc_filter
  import diff_pkg::*;
#(
  parameter int DW  = 12,
  parameter int NCH = 4,
  parameter int OW  = DW + 2
) (
  input  logic             clk,
  input  logic             rst,
  diff_mc_filter_if.slave  bus
);

  localparam int CW = chan_w(NCH);

`ifndef DIFF_SAT_EN
  // Without saturation the output must carry the full difference range
  if (OW != DW + 2) begin : g_ow_chk
    $error("diff_mc_filter: OW must equal DW+2 when DIFF_SAT_EN is not defined");
  end
`endif

  logic [2:0]           state_q, state_d;
  logic [DW-1:0]        x_q;
  logic [CW-1:0]        chan_q;
  logic                 ord_q;
  logic                 out_valid_q;
  logic signed [OW-1:0] out_data_q;
  logic [CW-1:0]        out_chan_q;
  logic                 out_primed_q;
  logic                 sat_q;

  logic [DW-1:0]        rd_h1, rd_h2;
  logic [1:0]           rd_cnt;
  logic                 chan_ok;
  logic                 accept;
  logic                 calc;
  logic signed [31:0]   diff32;
  logic signed [OW-1:0] res;
  logic                 res_sat;
  logic                 primed;
  logic                 unused_hi;

  assign accept = (state_q == IDLE) && bus.in_valid;
  assign calc   = (state_q == CALC);

  // Channels beyond NCH are echoed but never touch history
  if ((1 << CW) <= NCH) begin : g_chan_full
    assign chan_ok = 1'b1;
  end else begin : g_chan_part
    assign chan_ok = (32'(chan_q) < NCH);
  end

  diff_hist_bank #(.DW(DW), .NCH(NCH), .CW(CW)) u_hist (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (bus.clr_hist),
    .rd_chan_i (chan_q),
    .rd_h1_o   (rd_h1),
    .rd_h2_o   (rd_h2),
    .rd_cnt_o  (rd_cnt),
    .wr_en_i   (calc && chan_ok),
    .wr_chan_i (chan_q),
    .wr_x_i    (x_q)
  );

  assign diff32 = diff_calc(32'(x_q), 32'(rd_h1), 32'(rd_h2), ord_q);

`ifdef DIFF_SAT_EN
  localparam logic signed [31:0] OMAX = (32'sd1 <<< (OW - 1)) - 32'sd1;
  localparam logic signed [31:0] OMIN = -(32'sd1 <<< (OW - 1));
  logic signed [31:0] clamped;

  // Clamp the full-precision difference into the signed OW range
  always_comb begin
    clamped = diff32;
    res_sat = 1'b0;
    if (diff32 > OMAX) begin
      clamped = OMAX;
      res_sat = 1'b1;
    end else if (diff32 < OMIN) begin
      clamped = OMIN;
      res_sat = 1'b1;
    end
  end
  assign res       = clamped[OW-1:0];
  assign unused_hi = ^clamped[31:OW];
`else
  assign res       = diff32[OW-1:0];
  assign res_sat   = 1'b0;
  assign unused_hi = ^diff32[31:OW];
`endif

  // Primed means the history already held enough samples for the selected order
  assign primed = (ord_q == ORD2) ? (rd_cnt >= 2'd2) : (rd_cnt >= 2'd1);

  // Next-state logic of the IDLE -> CALC -> HOLD loop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = CALC;
      CALC:                       state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Capture the accepted sample for the CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      chan_q <= '0;
      ord_q  <= ORD1;
    end else if (accept) begin
      x_q    <= bus.in_data;
      chan_q <= bus.in_chan;
      ord_q  <= bus.in_order;
    end
  end

  // Result register: loaded in CALC, held through HOLD until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_primed_q <= 1'b0;
      sat_q        <= 1'b0;
    end else if (calc) begin
      out_valid_q  <= 1'b1;
      out_data_q   <= chan_ok ? res : '0;
      out_chan_q   <= chan_q;
      out_primed_q <= chan_ok && primed;
      sat_q        <= chan_ok && res_sat;
    end else if ((state_q == HOLD) && bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_chan   = out_chan_q;
  assign bus.out_primed = out_primed_q;
`ifdef DIFF_SAT_EN
  assign bus.out_sat    = sat_q;
`endif

endmodule

// File: tb/tb_diff_mc_filter.sv
// Directed bench for diff_mc_filter with hand-computed expected results.
// Drives at posedge+1 and samples at posedge+1; each sample runs IDLE->CALC->HOLD.
// Covers priming, channel isolation, backpressure hold, clr_hist race and async reset.
module tb_diff_mc_filter;
  import diff_pkg::*;

  localparam int DW  = 12;
  localparam int NCH = 4;
`ifdef DIFF_SAT_EN
  localparam int OW  = 13;
`else
  localparam int OW  = DW + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  diff_mc_filter_if #(.DW(DW), .NCH(NCH), .OW(OW)) bus ();

  diff_mc_filter #(.DW(DW), .NCH(NCH), .OW(OW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sample through the full loop; out_ready is assumed high on entry
  task automatic run_smp(input int ch, input int d, input logic ord, input logic clr,
                         input int exp_d, input logic exp_p, input logic exp_s, input string tag);
    for (int n = 0; n < 10 && !bus.in_ready; n++) @(posedge clk) #1;
    chk({tag, "_rdy"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_chan  = ch[1:0];
    bus.in_data  = d[DW-1:0];
    bus.in_order = ord;
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    bus.clr_hist = clr;
    chk({tag, "_vld_calc"}, 32'(bus.out_valid), 0);
    @(posedge clk) #1;
    bus.clr_hist = 1'b0;
    chk({tag, "_vld"}, 32'(bus.out_valid), 1);
    chk({tag, "_dat"}, 32'($signed(bus.out_data)), exp_d);
    chk({tag, "_chan"}, 32'(bus.out_chan), ch);
    chk({tag, "_prm"}, 32'(bus.out_primed), 32'(exp_p));
`ifdef DIFF_SAT_EN
    chk({tag, "_sat"}, 32'(bus.out_sat), 32'(exp_s));
`else
    if (exp_s) chk({tag, "_sat_unexpected"}, 0, 1);
`endif
    @(posedge clk) #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_chan   = '0;
    bus.in_order  = ORD1;
    bus.clr_hist  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // First post-reset cycle
    chk("rst_rdy", 32'(bus.in_ready), 1);
    chk("rst_vld", 32'(bus.out_valid), 0);
    chk("rst_dat", 32'($signed(bus.out_data)), 0);
    chk("rst_prm", 32'(bus.out_primed), 0);

    // Channel 0, second order: priming ramp
    run_smp(0, 100, ORD2, 0,  100, 0, 0, "c0a");
    run_smp(0, 300, ORD2, 0,  100, 0, 0, "c0b");
    run_smp(0, 200, ORD2, 0, -300, 1, 0, "c0c");

    // Interleaved channels 1/2, first order: no leakage
    run_smp(1, 4095, ORD1, 0, 4095, 0, 0, "c1a");
    run_smp(2, 7,    ORD1, 0, 7,    0, 0, "c2a");
    run_smp(1, 4095, ORD1, 0, 0,    1, 0, "c1b");
    run_smp(2, 7,    ORD1, 0, 0,    1, 0, "c2b");

    // Channel 3 extremes
    run_smp(3, 0,    ORD2, 0, 0,    0, 0, "c3a");
    run_smp(3, 4095, ORD2, 0, 4095, 0, 0, "c3b");
`ifdef DIFF_SAT_EN
    run_smp(3, 0,    ORD2, 0, -4096, 1, 1, "c3c");
`else
    run_smp(3, 0,    ORD2, 0, -8190, 1, 0, "c3c");
`endif

    // Backpressure: hold result 5 cycles with a competing sample pending
    bus.in_valid = 1'b1;
    bus.in_chan  = 2'd1;
    bus.in_data  = 12'd100;
    bus.in_order = ORD1;
    @(posedge clk) #1;
    bus.out_ready = 1'b0;
    bus.in_chan   = 2'd2;
    bus.in_data   = 12'd20;
    @(posedge clk) #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld", 32'(bus.out_valid), 1);
      chk("bp_dat", 32'($signed(bus.out_data)), -3995);
      chk("bp_chan", 32'(bus.out_chan), 1);
      chk("bp_rdy", 32'(bus.in_ready), 0);
      @(posedge clk) #1;
    end
    bus.out_ready = 1'b1;
    run_smp(2, 20, ORD1, 0, 13, 1, 0, "bp_next");

    // Order change on channel 2 (h1=20, h2=7)
    run_smp(2, 30, ORD2, 0, -3, 1, 0, "c2ord");

    // clr_hist: stand-alone clear, re-prime, then clear during CALC
    bus.clr_hist = 1'b1;
    @(posedge clk) #1;
    bus.clr_hist = 1'b0;
    run_smp(0, 100, ORD2, 0, 100,  0, 0, "clr_a");
    run_smp(0, 300, ORD2, 0, 100,  0, 0, "clr_b");
    run_smp(0, 50,  ORD2, 1, -450, 1, 0, "clr_c");
    run_smp(0, 10,  ORD2, 0, 10,   0, 0, "clr_d");
    run_smp(1, 5,   ORD1, 0, 5,    0, 0, "clr_c1");

    // Asynchronous reset while a result is held
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_chan   = 2'd1;
    bus.in_data   = 12'd77;
    bus.in_order  = ORD1;
    @(posedge clk) #1;
    bus.in_valid = 1'b0;
    @(posedge clk) #1;
    chk("ar_hold_vld", 32'(bus.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("ar_vld", 32'(bus.out_valid), 0);
    chk("ar_dat", 32'($signed(bus.out_data)), 0);
    @(posedge clk) #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    run_smp(1, 9, ORD1, 0, 9, 0, 0, "ar_hist");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
